// File: rtl/wbu.sv
// Write-back / commit stage: holds one executed instruction, retires it to the
// GPR/CSR files, sequences ecall trap entry and drives the pipeline flush.
module wbu #(
  parameter logic [11:0] MEPC_ADDR   = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR = 12'h342,
  parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_ready,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_dnpc,
  input  logic [4:0]  in_gpr_waddr,
  input  logic [31:0] in_gpr_wdata,
  input  logic        in_zicsr,
  input  logic [11:0] in_csr_waddr,
  input  logic [31:0] in_csr_wdata,
  input  logic        in_exc,
  input  logic        in_ret,
  input  logic        in_fencei,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        gpr_wen,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  output logic        csr_wen,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [4:0]  wbu_rd,
  output logic [31:0] wbu_rd_val,
  output logic        commit_valid,
  output logic [31:0] commit_pc
);

  typedef enum logic [1:0] {IDLE, TRAP_EPC, TRAP_CAUSE, TRAP_JUMP} state_t;

  state_t      state, state_next;
  logic        valid;
  logic [31:0] pc, dnpc;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic        zicsr, exc, ret, fencei;
  logic [11:0] csr_addr;
  logic [31:0] csr_data;
  logic        commit_now;
  logic        accept;

  // Handshake: a transfer happens on a rising edge where in_valid & in_ready;
  // the producer holds in_* stable while in_valid is high and in_ready is low.
  // in_ready depends only on the held entry, never on in_valid.
  assign in_ready = (~valid | commit_now) & ~flush & ~reset;
  assign accept   = in_ready & in_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid    <= 1'b0;
      pc       <= '0;
      dnpc     <= '0;
      rd       <= '0;
      rd_data  <= '0;
      zicsr    <= 1'b0;
      csr_addr <= '0;
      csr_data <= '0;
      exc      <= 1'b0;
      ret      <= 1'b0;
      fencei   <= 1'b0;
    end else if (accept) begin
      valid    <= 1'b1;
      pc       <= in_pc;
      dnpc     <= in_dnpc;
      rd       <= in_gpr_waddr;
      rd_data  <= in_gpr_wdata;
      zicsr    <= in_zicsr;
      csr_addr <= in_csr_waddr;
      csr_data <= in_csr_wdata;
      exc      <= in_exc;
      ret      <= in_ret;
      fencei   <= in_fencei;
    end else if (commit_now) begin
      valid <= 1'b0;
    end
  end

  always_comb begin
    state_next  = state;
    commit_now  = 1'b0;
    gpr_wen     = 1'b0;
    csr_wen     = 1'b0;
    csr_waddr   = csr_addr;
    csr_wdata   = csr_data;
    flush       = 1'b0;
    redirect_pc = '0;
    case (state)
      IDLE: begin
        if (valid) begin
          if (exc) begin
            state_next = TRAP_EPC;
          end else begin
            commit_now = 1'b1;
            gpr_wen    = (rd != 5'd0);
            csr_wen    = zicsr;
            // mret wins over the dnpc redirect of a co-flagged CSR/fence.i
            if (ret) begin
              flush       = 1'b1;
              redirect_pc = csr_mepc;
            end else if (zicsr | fencei) begin
              flush       = 1'b1;
              redirect_pc = dnpc;
            end
          end
        end
      end
      TRAP_EPC: begin
        csr_wen    = 1'b1;
        csr_waddr  = MEPC_ADDR;
        csr_wdata  = pc;
        state_next = TRAP_CAUSE;
      end
      TRAP_CAUSE: begin
        csr_wen    = 1'b1;
        csr_waddr  = MCAUSE_ADDR;
        csr_wdata  = ECALL_CAUSE;
        state_next = TRAP_JUMP;
      end
      TRAP_JUMP: begin
        flush       = 1'b1;
        redirect_pc = csr_mtvec;
        commit_now  = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign gpr_waddr    = rd;
  assign gpr_wdata    = rd_data;
  assign commit_valid = commit_now;
  assign commit_pc    = pc;
  assign wbu_rd       = (valid & ~exc) ? rd : 5'd0;
  assign wbu_rd_val   = rd_data;

endmodule

// File: tb/tb_wbu.sv
// Bench for wbu: directed walk through the commit/trap scenarios, then a random
// instruction stream checked against a per-instruction output schedule model.
module tb_wbu;

  localparam logic [11:0] MEPC_ADDR   = 12'h341;
  localparam logic [11:0] MCAUSE_ADDR = 12'h342;
  localparam logic [31:0] ECALL_CAUSE = 32'd11;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_MEPC  = 2'd1;
  localparam logic [1:0] SRC_MTVEC = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_ready, in_valid;
  logic [31:0] in_pc, in_dnpc;
  logic [4:0]  in_gpr_waddr;
  logic [31:0] in_gpr_wdata;
  logic        in_zicsr;
  logic [11:0] in_csr_waddr;
  logic [31:0] in_csr_wdata;
  logic        in_exc, in_ret, in_fencei;
  logic [31:0] csr_mtvec, csr_mepc;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [4:0]  wbu_rd;
  logic [31:0] wbu_rd_val;
  logic        commit_valid;
  logic [31:0] commit_pc;

  wbu dut (
    .clock(clock), .reset(reset),
    .in_ready(in_ready), .in_valid(in_valid), .in_pc(in_pc), .in_dnpc(in_dnpc),
    .in_gpr_waddr(in_gpr_waddr), .in_gpr_wdata(in_gpr_wdata), .in_zicsr(in_zicsr),
    .in_csr_waddr(in_csr_waddr), .in_csr_wdata(in_csr_wdata), .in_exc(in_exc),
    .in_ret(in_ret), .in_fencei(in_fencei), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .flush(flush), .redirect_pc(redirect_pc), .wbu_rd(wbu_rd), .wbu_rd_val(wbu_rd_val),
    .commit_valid(commit_valid), .commit_pc(commit_pc)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [4:0]  wbu_rd;
    logic [31:0] wbu_rd_val;
  } out_t;

  typedef struct packed {
    out_t       o;
    logic [1:0] src;
  } sched_t;

  // One entry per cycle the accepted instruction occupies the stage.
  sched_t exp_q[$];

  int   tests = 0;
  int   fails = 0;
  out_t last_obs;
  logic last_rdy;
  logic last_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_zero(input string tag);
    logic [250:0] all_out;
    all_out = {in_ready, gpr_wen, gpr_waddr, gpr_wdata, csr_wen, csr_waddr, csr_wdata,
               flush, redirect_pc, wbu_rd, wbu_rd_val, commit_valid, commit_pc};
    tests++;
    assert (all_out === '0) else begin
      fails++;
      $error("FAIL %s outputs got %h expected 0", tag, all_out);
    end
  endtask

  // Expected per-cycle outputs for the instruction currently on in_*.
  task automatic push_sched();
    sched_t s;
    s = '0;
    s.o.wbu_rd_val = in_gpr_wdata;
    if (in_exc) begin
      exp_q.push_back(s);
      s.o.csr_wen   = 1'b1;
      s.o.csr_waddr = MEPC_ADDR;
      s.o.csr_wdata = in_pc;
      exp_q.push_back(s);
      s.o.csr_waddr = MCAUSE_ADDR;
      s.o.csr_wdata = ECALL_CAUSE;
      exp_q.push_back(s);
      s.o.csr_wen      = 1'b0;
      s.o.csr_waddr    = '0;
      s.o.csr_wdata    = '0;
      s.o.flush        = 1'b1;
      s.src            = SRC_MTVEC;
      s.o.commit_valid = 1'b1;
      s.o.commit_pc    = in_pc;
      exp_q.push_back(s);
    end else begin
      s.o.gpr_wen      = (in_gpr_waddr != 0);
      s.o.gpr_waddr    = s.o.gpr_wen ? in_gpr_waddr : 5'd0;
      s.o.gpr_wdata    = s.o.gpr_wen ? in_gpr_wdata : 32'd0;
      s.o.csr_wen      = in_zicsr;
      s.o.csr_waddr    = in_zicsr ? in_csr_waddr : 12'd0;
      s.o.csr_wdata    = in_zicsr ? in_csr_wdata : 32'd0;
      s.o.flush        = in_ret | in_zicsr | in_fencei;
      s.src            = in_ret ? SRC_MEPC : SRC_NONE;
      s.o.redirect_pc  = (!in_ret && s.o.flush) ? in_dnpc : 32'd0;
      s.o.commit_valid = 1'b1;
      s.o.commit_pc    = in_pc;
      s.o.wbu_rd       = in_gpr_waddr;
      exp_q.push_back(s);
    end
  endtask

  // One clock: compare outputs at negedge, retire the model, record acceptance.
  task automatic cycle(input string tag);
    out_t obs, e;
    logic held, rdy_exp;
    @(negedge clock);
    held = (exp_q.size() != 0);
    e = '0;
    if (held) begin
      e = exp_q[0].o;
      if (exp_q[0].src == SRC_MEPC)  e.redirect_pc = csr_mepc;
      if (exp_q[0].src == SRC_MTVEC) e.redirect_pc = csr_mtvec;
    end
    rdy_exp = !held || (exp_q.size() == 1 && e.commit_valid && !e.flush);
    obs.gpr_wen      = gpr_wen;
    obs.gpr_waddr    = gpr_wen ? gpr_waddr : 5'd0;
    obs.gpr_wdata    = gpr_wen ? gpr_wdata : 32'd0;
    obs.csr_wen      = csr_wen;
    obs.csr_waddr    = csr_wen ? csr_waddr : 12'd0;
    obs.csr_wdata    = csr_wen ? csr_wdata : 32'd0;
    obs.flush        = flush;
    obs.redirect_pc  = flush ? redirect_pc : 32'd0;
    obs.commit_valid = commit_valid;
    obs.commit_pc    = commit_valid ? commit_pc : 32'd0;
    obs.wbu_rd       = wbu_rd;
    obs.wbu_rd_val   = held ? wbu_rd_val : 32'd0;
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s outputs got %h expected %h", tag, obs, e);
    end
    tests++;
    assert (in_ready === rdy_exp) else begin
      fails++;
      $error("FAIL %s_in_ready got %b expected %b", tag, in_ready, rdy_exp);
    end
    last_obs = obs;
    last_rdy = in_ready;
    last_acc = in_ready & in_valid;
    if (held) void'(exp_q.pop_front());
    if (last_acc) push_sched();
    @(posedge clock);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] pc, input logic [31:0] dnpc, input logic [4:0] rd,
                       input logic [31:0] wd, input logic z, input logic [11:0] ca,
                       input logic [31:0] cd, input logic e, input logic r, input logic f);
    in_valid     = 1'b1;
    in_pc        = pc;
    in_dnpc      = dnpc;
    in_gpr_waddr = rd;
    in_gpr_wdata = wd;
    in_zicsr     = z;
    in_csr_waddr = ca;
    in_csr_wdata = cd;
    in_exc       = e;
    in_ret       = r;
    in_fencei    = f;
  endtask

  task automatic drive_plain(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] wd);
    drive(pc, pc + 32'd4, rd, wd, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_random();
    int          k;
    logic [31:0] pc;
    k  = $urandom_range(0, 9);
    pc = $urandom & 32'hFFFF_FFFC;
    drive(pc, $urandom & 32'hFFFF_FFFC, (k == 5) ? 5'd0 : 5'($urandom_range(0, 31)), $urandom,
          (k == 6) || (k == 8 && $urandom_range(0, 1) == 1), 12'($urandom), $urandom,
          (k == 9), (k == 8), (k == 7));
    in_valid = ($urandom_range(0, 3) != 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    drive_plain(32'd0, 5'd0, 32'd0);
    in_valid  = 1'b0;
    csr_mtvec = 32'd0;
    csr_mepc  = 32'd0;
    last_acc  = 1'b0;

    @(negedge clock);
    check_reset_zero("reset_hold");
    @(posedge clock);
    #1 reset = 1'b0;
    cycle("post_reset");
    chk("post_reset_ready", {31'd0, last_rdy}, 32'd1);

    // plain back-to-back stream, then rd=x0
    drive_plain(32'h8000_0000, 5'd5, 32'h11);
    cycle("plain_acc0");
    drive_plain(32'h8000_0004, 5'd6, 32'h22);
    cycle("plain0");
    chk("plain0_pc", last_obs.commit_pc, 32'h8000_0000);
    chk("plain0_wen", {31'd0, last_obs.gpr_wen}, 32'd1);
    drive_plain(32'h8000_0008, 5'd0, 32'hDEAD);
    cycle("plain1");
    chk("plain1_pc", last_obs.commit_pc, 32'h8000_0004);
    chk("plain1_wdata", last_obs.gpr_wdata, 32'h22);
    chk("plain1_ready", {31'd0, last_rdy}, 32'd1);

    // csrrw, with a plain instruction waiting behind it
    drive(32'h8000_000C, 32'h8000_0010, 5'd7, 32'h1800, 1'b1, 12'h300, 32'h8, 1'b0, 1'b0, 1'b0);
    cycle("rd0");
    chk("rd0_wen", {31'd0, last_obs.gpr_wen}, 32'd0);
    chk("rd0_commit", {31'd0, last_obs.commit_valid}, 32'd1);
    drive_plain(32'h8000_0010, 5'd8, 32'h33);
    cycle("csrrw");
    chk("csrrw_flush", {31'd0, last_obs.flush}, 32'd1);
    chk("csrrw_redirect", last_obs.redirect_pc, 32'h8000_0010);
    chk("csrrw_csr", {last_obs.csr_waddr, 20'd0}, {12'h300, 20'd0});
    chk("csrrw_gpr", {27'd0, last_obs.gpr_waddr}, 32'd7);
    chk("csrrw_ready", {31'd0, last_rdy}, 32'd0);
    cycle("after_csrrw");
    chk("after_csrrw_flush", {31'd0, last_obs.flush}, 32'd0);

    // ecall trap sequence
    csr_mtvec = 32'h8000_1000;
    drive(32'h8000_0020, 32'h8000_0024, 5'd4, 32'h77, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    cycle("ecall_acc");
    drive_plain(32'h8000_0024, 5'd9, 32'h44);
    cycle("trap_bubble");
    chk("trap_bubble_csr", {31'd0, last_obs.csr_wen}, 32'd0);
    chk("trap_bubble_rd", {27'd0, wbu_rd}, 32'd0);
    cycle("trap_epc");
    chk("trap_epc_addr", {20'd0, last_obs.csr_waddr}, 32'h341);
    chk("trap_epc_data", last_obs.csr_wdata, 32'h8000_0020);
    cycle("trap_cause");
    chk("trap_cause_addr", {20'd0, last_obs.csr_waddr}, 32'h342);
    chk("trap_cause_data", last_obs.csr_wdata, 32'd11);
    cycle("trap_jump");
    chk("trap_jump_redirect", last_obs.redirect_pc, 32'h8000_1000);
    chk("trap_jump_gpr", {31'd0, last_obs.gpr_wen}, 32'd0);
    chk("trap_jump_ready", {31'd0, last_rdy}, 32'd0);
    cycle("post_trap");
    chk("post_trap_ready", {31'd0, last_rdy}, 32'd1);

    // mret
    csr_mepc = 32'h8000_0024;
    drive(32'h8000_0030, 32'h8000_0034, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    cycle("mret_acc");
    in_valid = 1'b0;
    cycle("mret");
    chk("mret_flush", {31'd0, last_obs.flush}, 32'd1);
    chk("mret_redirect", last_obs.redirect_pc, 32'h8000_0024);

    // reset while in TRAP_CAUSE
    drive(32'h8000_0040, 32'h8000_0044, 5'd3, 32'h99, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    cycle("rt_acc");
    in_valid = 1'b0;
    cycle("rt_bubble");
    cycle("rt_epc");
    reset = 1'b1;
    #1;
    check_reset_zero("reset_mid_trap");
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle("rt_after");
    drive_plain(32'h8000_0100, 5'd10, 32'h55);
    cycle("rt_new_acc");
    in_valid = 1'b0;
    cycle("rt_new");
    chk("rt_new_commit", last_obs.commit_pc, 32'h8000_0100);

    // random stream; a refused instruction is held until accepted
    for (int n = 0; n < 800; n++) begin
      if (!in_valid || last_acc) drive_random();
      csr_mepc  = $urandom & 32'hFFFF_FFFC;
      csr_mtvec = $urandom & 32'hFFFF_FFFC;
      cycle("rand");
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) cycle("drain");
    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL drain_empty got %0d expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
